// File: rtl/uart_duplex_pkg.sv
// Shared encodings for the duplex UART: parity modes, frame FSM states and parity helpers.
// Pure declarations: no latency and no backpressure of its own.
package uart_duplex_pkg;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Even mode yields the bit that makes the total count of ones even.
    function automatic logic parity_calc(input logic [1:0] mode, input logic [7:0] dat);
        return (mode == PAR_ODD) ? ~(^dat) : (^dat);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; read data valid combinationally from the head, write visible next cycle.
// Writes at full are dropped unless a read happens in the same cycle; reads at empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int EXP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int DEPTH = 1 << EXP;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [EXP:0]     r_wr_ptr;
    logic [EXP:0]     r_rd_ptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[EXP] != r_rd_ptr[EXP]) &&
                      (r_wr_ptr[EXP-1:0] == r_rd_ptr[EXP-1:0]);
    assign w_do_rd  = i_rd && !o_empty;
    assign w_do_wr  = i_wr && (!o_full || w_do_rd);
    assign o_rd_dat = o_empty ? '0 : r_mem[r_rd_ptr[EXP-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[EXP-1:0]] <= i_wr_dat;
    end

endmodule

// File: rtl/uart_duplex.sv
// Full-duplex UART with runtime baud divisor, optional parity, 1/2 stop bits, loopback and RX/TX FIFOs.
// RX pin reaches the FSM after 2 sync cycles; tx_full/rx_full signal backpressure, overflowing RX bytes set overrun.
module uart_duplex #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_EXP   = 4,
    parameter int DIV_BITS   = 16
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DIV_BITS-1:0]  baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 loopback,
    input  logic                 tx_wr,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_full,
    input  logic                 err_clr,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    import uart_duplex_pkg::*;

    localparam int TCW = $clog2(2 * OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [TCW-1:0] T_HALF = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] T_BIT  = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] T_TWO  = TCW'(2 * OVERSAMPLE - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);

    // Baud tick generator; the divisor is only resampled at wrap so a tick period is never cut short.
    logic [DIV_BITS-1:0] r_div;
    logic [DIV_BITS-1:0] r_baud_cnt;
    logic                w_tick;

    assign w_tick = (r_div != '0) && (r_baud_cnt == r_div - 1'b1);

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_baud_cnt <= '0;
        end else if (r_div == '0) begin
            r_div      <= baud_div;
            r_baud_cnt <= '0;
        end else if (w_tick) begin
            r_div      <= baud_div;
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    logic       r_tx_line;
    logic [1:0] r_sync;
    logic       r_rx_prev;
    logic       w_rx_src;
    logic       w_rx_in;
    logic       w_rx_fall;

    assign w_rx_src  = loopback ? r_tx_line : rx;
    assign w_rx_in   = r_sync[1];
    assign w_rx_fall = r_rx_prev && !r_sync[1];
    assign tx        = loopback ? 1'b1 : r_tx_line;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], w_rx_src};
            r_rx_prev <= r_sync[1];
        end
    end

    uart_state_e          r_rx_st;
    logic [TCW-1:0]       r_rx_tcnt;
    logic [BCW-1:0]       r_rx_bcnt;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [1:0]           r_rx_pmode;
    logic                 r_rx_wr;

    // Error flags: clear is scheduled first so a same-cycle set overrides it.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_rx_st    <= ST_IDLE;
            r_rx_tcnt  <= '0;
            r_rx_bcnt  <= '0;
            r_rx_shift <= '0;
            r_rx_pmode <= PAR_NONE;
            r_rx_wr    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_rx_wr <= 1'b0;
            if (err_clr) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
            case (r_rx_st)
                ST_IDLE: if (w_rx_fall) begin
                    r_rx_st    <= ST_START;
                    r_rx_tcnt  <= '0;
                    r_rx_pmode <= parity_mode;
                end
                ST_START: if (w_tick) begin
                    if (r_rx_tcnt == T_HALF) begin
                        r_rx_tcnt <= '0;
                        r_rx_bcnt <= '0;
                        r_rx_st   <= w_rx_in ? ST_IDLE : ST_DATA;
                    end else r_rx_tcnt <= r_rx_tcnt + 1'b1;
                end
                ST_DATA: if (w_tick) begin
                    if (r_rx_tcnt == T_BIT) begin
                        r_rx_tcnt  <= '0;
                        r_rx_shift <= {w_rx_in, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bcnt  <= r_rx_bcnt + 1'b1;
                        if (r_rx_bcnt == B_LAST)
                            r_rx_st <= parity_on(r_rx_pmode) ? ST_PARITY : ST_STOP;
                    end else r_rx_tcnt <= r_rx_tcnt + 1'b1;
                end
                ST_PARITY: if (w_tick) begin
                    if (r_rx_tcnt == T_BIT) begin
                        r_rx_tcnt <= '0;
                        r_rx_st   <= ST_STOP;
                        if (w_rx_in != parity_calc(r_rx_pmode, 8'(r_rx_shift))) parity_err <= 1'b1;
                    end else r_rx_tcnt <= r_rx_tcnt + 1'b1;
                end
                ST_STOP: if (w_tick) begin
                    if (r_rx_tcnt == T_BIT) begin
                        r_rx_tcnt <= '0;
                        r_rx_st   <= ST_IDLE;
                        if (!w_rx_in)    frame_err <= 1'b1;
                        else if (rx_full) overrun  <= 1'b1;
                        else             r_rx_wr   <= 1'b1;
                    end else r_rx_tcnt <= r_rx_tcnt + 1'b1;
                end
                default: r_rx_st <= ST_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .EXP(FIFO_EXP)) u_rx_fifo (
        .clk(clk_50MHz), .rst_n(reset),
        .i_wr(r_rx_wr), .i_wr_dat(r_rx_shift),
        .i_rd(rx_rd), .o_rd_dat(rx_data),
        .o_empty(rx_empty), .o_full(rx_full)
    );

    uart_state_e          r_tx_st;
    logic [TCW-1:0]       r_tx_tcnt;
    logic [BCW-1:0]       r_tx_bcnt;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [1:0]           r_tx_pmode;
    logic                 r_tx_two;
    logic                 r_tx_par;
    logic                 w_tx_empty;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_stop_end;
    logic                 w_tx_pop;

    assign w_tx_stop_end = (r_tx_st == ST_STOP) && (r_tx_tcnt == (r_tx_two ? T_TWO : T_BIT));
    // Popping at the end of STOP chains frames back-to-back with no idle gap.
    assign w_tx_pop = w_tick && !w_tx_empty && ((r_tx_st == ST_IDLE) || w_tx_stop_end);

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_tx_st    <= ST_IDLE;
            r_tx_tcnt  <= '0;
            r_tx_bcnt  <= '0;
            r_tx_shift <= '0;
            r_tx_pmode <= PAR_NONE;
            r_tx_two   <= 1'b0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
            tx_busy    <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_st    <= ST_START;
            r_tx_tcnt  <= '0;
            r_tx_shift <= w_tx_head;
            r_tx_pmode <= parity_mode;
            r_tx_two   <= two_stop;
            r_tx_par   <= parity_calc(parity_mode, 8'(w_tx_head));
            r_tx_line  <= 1'b0;
            tx_busy    <= 1'b1;
        end else if (w_tick) begin
            case (r_tx_st)
                ST_START: if (r_tx_tcnt == T_BIT) begin
                    r_tx_tcnt <= '0;
                    r_tx_bcnt <= '0;
                    r_tx_line <= r_tx_shift[0];
                    r_tx_st   <= ST_DATA;
                end else r_tx_tcnt <= r_tx_tcnt + 1'b1;
                ST_DATA: if (r_tx_tcnt == T_BIT) begin
                    r_tx_tcnt <= '0;
                    if (r_tx_bcnt == B_LAST) begin
                        r_tx_line <= parity_on(r_tx_pmode) ? r_tx_par : 1'b1;
                        r_tx_st   <= parity_on(r_tx_pmode) ? ST_PARITY : ST_STOP;
                    end else begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_line  <= r_tx_shift[1];
                        r_tx_bcnt  <= r_tx_bcnt + 1'b1;
                    end
                end else r_tx_tcnt <= r_tx_tcnt + 1'b1;
                ST_PARITY: if (r_tx_tcnt == T_BIT) begin
                    r_tx_tcnt <= '0;
                    r_tx_line <= 1'b1;
                    r_tx_st   <= ST_STOP;
                end else r_tx_tcnt <= r_tx_tcnt + 1'b1;
                ST_STOP: if (w_tx_stop_end) begin
                    r_tx_st <= ST_IDLE;
                    tx_busy <= 1'b0;
                end else r_tx_tcnt <= r_tx_tcnt + 1'b1;
                default: ;
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .EXP(FIFO_EXP)) u_tx_fifo (
        .clk(clk_50MHz), .rst_n(reset),
        .i_wr(tx_wr), .i_wr_dat(tx_data),
        .i_rd(w_tx_pop), .o_rd_dat(w_tx_head),
        .o_empty(w_tx_empty), .o_full(tx_full)
    );

endmodule

// File: tb/tb_uart_duplex.sv
// Self-checking bench for uart_duplex: table of RX frames, randomized loopback traffic against a queue model,
// and hand-written sequences for two-stop TX timing, overrun, glitch and asynchronous reset.
module tb_uart_duplex;
    localparam int DB = 8;
    localparam int OS = 16;
    localparam int FE = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          tx;
    logic [DW-1:0] baud_div = 16'd4;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop = 1'b0;
    logic          loopback = 1'b0;
    logic          tx_wr = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_full, tx_busy;
    logic          rx_rd = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_empty, rx_full;
    logic          err_clr = 1'b0;
    logic          parity_err, frame_err, overrun;

    always #10 clk = ~clk;

    uart_duplex #(.DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_EXP(FE), .DIV_BITS(DW)) dut (
        .clk_50MHz(clk), .reset(rst_n), .rx(rx), .tx(tx),
        .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop), .loopback(loopback),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_busy(tx_busy),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full),
        .err_clr(err_clr), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
    );

    int n_chk = 0;
    int n_err = 0;
    int bp = OS * 4;
    int tx_low = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin n_err++; $display("FAIL %s: got %b want %b", name, act, exp); end
    endtask
    task automatic chk_d(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin n_err++; $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp); end
    endtask
    task automatic chk_i(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin n_err++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
    endtask

    // Reference parity from the count of ones: even mode makes the total even, odd mode makes it odd.
    function automatic logic exp_parity(input logic [1:0] m, input logic [7:0] d);
        int ones = $countones(d);
        return (m == 2'b01) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    endfunction

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (bp) @(negedge clk);
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic [1:0] m, input logic flip, input logic stopv);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (m == 2'b01 || m == 2'b10) drive_bit(exp_parity(m, d) ^ flip);
        drive_bit(stopv);
        drive_bit(1'b1);
    endtask

    task automatic push(input logic [7:0] d);
        tx_data = d; tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_rx(input int maxc, output int cyc);
        cyc = 0;
        while (rx_empty && cyc < maxc) begin
            @(negedge clk);
            if (tx == 1'b0) tx_low++;
            cyc++;
        end
    endtask

    task automatic set_div(input int d);
        baud_div = DW'(d);
        bp = OS * d;
        repeat (64) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic       flip;
        logic       stopv;
        logic       exp_stored;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vt[7];
    logic [7:0] q[$];
    logic tx_s[1600];
    logic busy_s[1600];
    logic exp_bits[$];

    initial begin
        int cyc, f, len, bad, n;
        logic [7:0] d;

        vt[0] = '{8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{8'h03, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2] = '{8'h81, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3] = '{8'h7E, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{8'hFF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'hB4, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6] = '{8'h00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk_b("rst tx", tx, 1'b1);
        chk_b("rst tx_busy", tx_busy, 1'b0);
        chk_b("rst tx_full", tx_full, 1'b0);
        chk_b("rst rx_full", rx_full, 1'b0);
        chk_b("rst rx_empty", rx_empty, 1'b1);
        chk_d("rst rx_data", rx_data, 8'h00);
        chk_b("rst parity_err", parity_err, 1'b0);
        chk_b("rst frame_err", frame_err, 1'b0);
        chk_b("rst overrun", overrun, 1'b0);
        rst_n = 1'b1;
        repeat (64) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            parity_mode = vt[i].m;
            drive_rx_frame(vt[i].d, vt[i].m, vt[i].flip, vt[i].stopv);
            chk_b($sformatf("vec%0d rx_empty", i), rx_empty, !vt[i].exp_stored);
            if (vt[i].exp_stored) begin
                chk_d($sformatf("vec%0d rx_data", i), rx_data, vt[i].d);
                pop();
            end
            chk_b($sformatf("vec%0d parity_err", i), parity_err, vt[i].exp_perr);
            chk_b($sformatf("vec%0d frame_err", i), frame_err, vt[i].exp_ferr);
            chk_b($sformatf("vec%0d overrun", i), overrun, 1'b0);
            clear_errs();
            chk_b($sformatf("vec%0d clr parity_err", i), parity_err, 1'b0);
            chk_b($sformatf("vec%0d clr frame_err", i), frame_err, 1'b0);
        end

        parity_mode = 2'b00;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (2 * bp) @(negedge clk);
        chk_b("glitch rx_empty", rx_empty, 1'b1);
        chk_b("glitch frame_err", frame_err, 1'b0);
        chk_b("glitch parity_err", parity_err, 1'b0);

        q.delete();
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom_range(0, 255));
            drive_rx_frame(d, 2'b00, 1'b0, 1'b1);
            if (i < 16) q.push_back(d);
        end
        chk_b("ovr rx_full", rx_full, 1'b1);
        chk_b("ovr overrun", overrun, 1'b1);
        bad = 0;
        while (q.size() > 0) begin
            d = q.pop_front();
            if (rx_data !== d) bad++;
            pop();
        end
        chk_i("ovr kept bytes mismatches", bad, 0);
        chk_b("ovr drained rx_empty", rx_empty, 1'b1);
        chk_b("ovr overrun sticky", overrun, 1'b1);
        clear_errs();
        chk_b("ovr clr overrun", overrun, 1'b0);

        loopback = 1'b1;
        tx_low = 0;
        for (int b = 0; b < 3; b++) begin
            parity_mode = 2'($urandom_range(0, 3));
            two_stop = 1'($urandom_range(0, 1));
            n = $urandom_range(2, 5);
            q.delete();
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom_range(0, 255));
                q.push_back(d);
                push(d);
            end
            while (q.size() > 0) begin
                d = q.pop_front();
                wait_rx(20 * bp, cyc);
                chk_b($sformatf("lb%0d got byte", b), rx_empty, 1'b0);
                chk_d($sformatf("lb%0d rx_data", b), rx_data, d);
                pop();
            end
            cyc = 0;
            while (tx_busy && cyc < 4 * bp) begin @(negedge clk); cyc++; end
            chk_b($sformatf("lb%0d tx_busy idle", b), tx_busy, 1'b0);
            chk_b($sformatf("lb%0d parity_err", b), parity_err, 1'b0);
            chk_b($sformatf("lb%0d frame_err", b), frame_err, 1'b0);
        end
        chk_i("loopback tx pin low samples", tx_low, 0);

        parity_mode = 2'b00;
        two_stop = 1'b0;
        set_div(0);
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 13 + 7);
            if (i < 16) q.push_back(d);
            push(d);
        end
        chk_b("halted tx_full", tx_full, 1'b1);
        chk_b("halted tx_busy", tx_busy, 1'b0);
        set_div(4);
        bad = 0;
        while (q.size() > 0) begin
            d = q.pop_front();
            wait_rx(20 * bp, cyc);
            if (rx_empty || rx_data !== d) bad++;
            pop();
        end
        chk_i("full tx fifo drain mismatches", bad, 0);
        repeat (24 * bp) @(negedge clk);
        chk_b("17th byte dropped", rx_empty, 1'b1);

        set_div(27);
        push(8'hA5);
        wait_rx(15 * bp, cyc);
        chk_b("a5 arrived", rx_empty, 1'b0);
        chk_b("a5 latency in 9..11 bits", (cyc >= 9 * bp) && (cyc <= 11 * bp), 1'b1);
        chk_d("a5 rx_data", rx_data, 8'hA5);
        chk_b("a5 parity_err", parity_err, 1'b0);
        chk_b("a5 frame_err", frame_err, 1'b0);
        pop();
        repeat (2 * bp) @(negedge clk);
        set_div(4);

        loopback = 1'b0;
        two_stop = 1'b1;
        tx_data = 8'h55; tx_wr = 1'b1;
        @(negedge clk);
        tx_data = 8'h00;
        @(negedge clk);
        tx_wr = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            tx_s[i] = tx;
            busy_s[i] = tx_busy;
            @(negedge clk);
        end
        exp_bits.delete();
        foreach (vt[k]) if (k < 2) begin
            d = (k == 0) ? 8'h55 : 8'h00;
            exp_bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) exp_bits.push_back(d[j]);
            exp_bits.push_back(1'b1);
            exp_bits.push_back(1'b1);
        end
        f = -1;
        for (int i = 0; i < 64; i++) if (f < 0 && tx_s[i] == 1'b0) f = i;
        chk_b("two_stop frame started", f >= 0, 1'b1);
        if (f >= 0) begin
            bad = 0;
            for (int k = 0; k < 22; k++) if (tx_s[f + 64 * k + 32] !== exp_bits[k]) bad++;
            chk_i("two_stop waveform bit errors", bad, 0);
            len = 0;
            for (int i = f + 9 * 64; i < 1600 && tx_s[i] == 1'b1; i++) len++;
            chk_i("two_stop stop length cycles", len, 2 * OS * 4);
            chk_b("two_stop busy at end of stop", busy_s[f + 1407], 1'b1);
            chk_b("two_stop busy after frames", busy_s[f + 1408], 1'b0);
            bad = 0;
            for (int i = f + 1408; i < 1600; i++) if (tx_s[i] !== 1'b1) bad++;
            chk_i("two_stop idle line low samples", bad, 0);
        end
        two_stop = 1'b0;

        drive_rx_frame(8'h5A, 2'b00, 1'b0, 1'b1);
        chk_b("pre-reset rx byte held", rx_empty, 1'b0);
        push(8'h00); push(8'h0F); push(8'hF0);
        repeat (3 * bp) @(negedge clk);
        chk_b("pre-reset tx_busy", tx_busy, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk_b("async rst tx", tx, 1'b1);
        chk_b("async rst tx_busy", tx_busy, 1'b0);
        chk_b("async rst rx_empty", rx_empty, 1'b1);
        chk_b("async rst tx_full", tx_full, 1'b0);
        chk_d("async rst rx_data", rx_data, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12 * bp; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk_i("post-reset tx fifo flushed", bad, 0);
        chk_b("post-reset rx_empty", rx_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

endmodule
